// File: rtl/riscv_pkg.sv
// Shared RV32I load/store codes, arbiter FSM states and helpers.
// Imported by the memory arbiter and its lane aligner.
package riscv_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } arb_state_t;

   function automatic logic ls_legal(
      input logic [2:0] t
   );
      return t inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
   endfunction

   function automatic logic ls_misaligned(
      input logic [2:0] t,
      input logic [1:0] a
   );
      logic r;
      r = 1'b0;
      if (t == LS_H || t == LS_HU)
         r = a[0];
      else if (t == LS_W)
         r = |a;
      return r;
   endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core-side and memory-side bus of the fetch/data memory arbiter.
// master = arbiter, slave = core ports plus memory.
interface core_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [2:0]        d_type;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ack;
   logic              d_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      input  if_req, if_addr,
      input  d_req, d_we, d_addr,
      input  d_type, d_wdata,
      input  mem_rdata, mem_ready,
      output if_rdata, if_ack,
      output d_rdata, d_ack, d_err,
      output mem_req, mem_we, mem_addr,
      output mem_be, mem_wdata
   );

   modport slave (
      output if_req, if_addr,
      output d_req, d_we, d_addr,
      output d_type, d_wdata,
      output mem_rdata, mem_ready,
      input  if_rdata, if_ack,
      input  d_rdata, d_ack, d_err,
      input  mem_req, mem_we, mem_addr,
      input  mem_be, mem_wdata
   );

endinterface

// File: rtl/core_mem_arbiter_lsu_align.sv
// Byte-enable / store-lane generation and load extraction,
// driven from the latched access type and byte offset.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  ls_type,
   input  logic [1:0]  ofs,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic        is_b;
   logic        is_h;
   logic        sx;
   logic [31:0] sh;

   assign is_b = (ls_type[1:0] == 2'b00);
   assign is_h = (ls_type[1:0] == 2'b01);
   assign sx   = ~ls_type[2];
   assign sh   = rdata >> {ofs, 3'b000};

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      rdata_ext  = rdata;
      unique case (1'b1)
         is_b: begin
            be         = 4'b0001 << ofs;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {{24{sx & sh[7]}},
                          sh[7:0]};
         end
         is_h: begin
            be         = 4'b0011 << ofs;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {{16{sx & sh[15]}},
                          sh[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Fetch/load-store arbiter in front of a single-ported memory,
// with per-transaction timeout and load extension.
module core_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   core_mem_arbiter_if.master bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST =
      CW'(TIMEOUT - 1);

   arb_state_t state_q;
   arb_state_t state_d;

   logic              gnt_d_q;
   logic              last_d_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        type_q;
   logic [31:0]       wdata_q;
   logic [31:0]       ird_q;
   logic [31:0]       drd_q;
   logic [CW-1:0]     cnt_q;

   logic        take_d;
   logic        take_f;
   logic        bad_d;
   logic        timeout;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic        if_ack;
   logic        d_ack;
   logic        d_err;
   logic [3:0]  be;
   logic [31:0] wlane;
   logic [31:0] rext;

   // Data wins unless it also won last time and fetch is waiting.
   assign take_d  = bus.d_req &&
                    !(bus.if_req && last_d_q);
   assign take_f  = bus.if_req && !take_d;
   assign bad_d   = !ls_legal(bus.d_type) ||
                    ls_misaligned(bus.d_type,
                                  bus.d_addr[1:0]);
   assign timeout = (cnt_q == TO_LAST);

   lsu_align u_align (
      .ls_type    (type_q),
      .ofs        (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata      (bus.mem_rdata),
      .be         (be),
      .wdata_lane (wlane),
      .rdata_ext  (rext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_be  = 4'b0000;
      if_ack  = 1'b0;
      d_ack   = 1'b0;
      d_err   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (take_d && bad_d)
               state_d = ST_RESP;
            else if (take_d || take_f)
               state_d = ST_BUSY;
         end
         ST_BUSY: begin
            mem_req = 1'b1;
            mem_we  = we_q;
            mem_be  = be;
            if (bus.mem_ready || timeout)
               state_d = ST_RESP;
         end
         ST_RESP: begin
            d_ack   = gnt_d_q;
            if_ack  = !gnt_d_q;
            d_err   = gnt_d_q && err_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_d_q  <= 1'b0;
         last_d_q <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         type_q   <= LS_B;
         wdata_q  <= '0;
         ird_q    <= '0;
         drd_q    <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (take_d || take_f) begin
                  gnt_d_q  <= take_d;
                  last_d_q <= take_d;
                  we_q     <= take_d && bus.d_we;
                  addr_q   <= take_d ? bus.d_addr
                                     : bus.if_addr;
                  type_q   <= take_d ? bus.d_type
                                     : LS_W;
                  wdata_q  <= take_d ? bus.d_wdata
                                     : '0;
                  err_q    <= take_d && bad_d;
                  cnt_q    <= '0;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               // Ready on the final cycle still completes cleanly.
               if (bus.mem_ready) begin
                  err_q <= 1'b0;
                  if (gnt_d_q)
                     drd_q <= we_q ? '0 : rext;
                  else
                     ird_q <= bus.mem_rdata;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (gnt_d_q)
                     drd_q <= '0;
                  else
                     ird_q <= NOP;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_be    = mem_be;
   assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.mem_wdata = wlane;
   assign bus.if_ack    = if_ack;
   assign bus.if_rdata  = ird_q;
   assign bus.d_ack     = d_ack;
   assign bus.d_err     = d_err;
   assign bus.d_rdata   = drd_q;

endmodule
